uart_tx_ctrl: RTL and testbench



---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_tx_ctrl_if.sv | 22 ++
 rtl/uart_fifo.sv | 54 +++++
 rtl/uart_tx_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit controller.
// State encoding, status-word bit positions, command bit and default baud.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int FULL_BIT = 15;
  localparam int BUSY_BIT = 14;
  localparam int OVF_BIT  = 13;
  localparam int CNT_LSB  = 8;
  localparam int CMD_BIT  = 15;

  // 25 MHz / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 217;

  // Even parity over one data byte: 1 when the byte holds an odd number of ones.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: memory-decoder side of the UART transmitter (IO2 slot).
// master = CPU/decoder side, slave = the transmit controller.
interface uart_tx_ctrl_if;
  logic        load;
  logic [15:0] in;
  logic [15:0] out;
  logic        tx;

  modport master (
    output load,
    output in,
    input  out,
    input  tx
  );

  modport slave (
    input  load,
    input  in,
    output out,
    output tx
  );
endinterface

// File: rtl/uart_fifo.sv
// uart_fifo: small synchronous byte queue with combinational head read.
// A push into a full queue is accepted when a pop happens on the same edge.
module uart_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [7:0]                 din,
  output logic [7:0]                 dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: memory-mapped 8N1 UART transmitter for the IO2 decoder slot.
// Build option: define UART_PARITY_EN to insert an even-parity bit between
// the data bits and the stop bit (11-tick frame instead of 10).
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | line high; pops the queue head when a byte is waiting
//   START  | start bit (tx=0) for one baud tick
//   DATA   | data bits LSB first, one tick each, bit_idx 0..7
//   PARITY | even parity bit for one tick (UART_PARITY_EN builds only)
//   STOP   | stop bit (tx=1) for one tick, then back to IDLE
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input logic           clk,
  input logic           reset,
  uart_tx_ctrl_if.slave bus
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic [7:0]    shift;
  logic [2:0]    bit_idx;
  logic          tick;
`ifdef UART_PARITY_EN
  logic          par_bit;
`endif

  logic          wr_data;
  logic          wr_cmd;
  logic          pop;
  logic          accepted;
  logic          dropped;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  logic          ovf;
  logic [7:0]    last_byte;
  logic          busy;
  logic [15:0]   status;
  logic          unused_in;

  // in[14:8] carry no meaning for either data or command writes.
  assign unused_in = ^bus.in[14:8];

  assign wr_data  = bus.load && !bus.in[CMD_BIT];
  assign wr_cmd   = bus.load &&  bus.in[CMD_BIT];
  assign pop      = (state == IDLE) && !fifo_empty;
  assign accepted = wr_data && (!fifo_full || pop);
  assign dropped  = wr_data && fifo_full && !pop;
  assign tick     = (baud_cnt == '0);
  assign busy     = (state != IDLE) || !fifo_empty;

  uart_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_data),
    .pop   (pop),
    .din   (bus.in[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Frame sequencer: tx is registered from the current state, so the line
  // trails the state by one clock; the baud counter reloads on every bit change.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      shift    <= '0;
      bit_idx  <= '0;
      bus.tx   <= 1'b1;
`ifdef UART_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bus.tx <= 1'b1;
          if (!fifo_empty) begin
            shift    <= fifo_dout;
            baud_cnt <= BAUD_RELOAD;
            state    <= START;
`ifdef UART_PARITY_EN
            par_bit  <= even_parity(fifo_dout);
`endif
          end
        end
        START: begin
          bus.tx <= 1'b0;
          if (tick) begin
            state    <= DATA;
            bit_idx  <= '0;
            baud_cnt <= BAUD_RELOAD;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        DATA: begin
          bus.tx <= shift[0];
          if (tick) begin
            shift    <= shift >> 1;
            baud_cnt <= BAUD_RELOAD;
            if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          bus.tx <= par_bit;
          if (tick) begin
            state    <= STOP;
            baud_cnt <= BAUD_RELOAD;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
`endif
        STOP: begin
          bus.tx <= 1'b1;
          if (tick) begin
            state <= IDLE;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: begin
          bus.tx <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Assemble the status word from the current registered state.
  always_comb begin
    status                     = '0;
    status[FULL_BIT]           = fifo_full;
    status[BUSY_BIT]           = busy;
    status[OVF_BIT]            = ovf;
    status[CNT_LSB +: 4]       = 4'(fifo_count);
    status[7:0]                = last_byte;
  end

  // Sticky overflow, last accepted byte and the registered status read path.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf       <= 1'b0;
      last_byte <= '0;
      bus.out   <= '0;
    end else begin
      if (wr_cmd)       ovf <= 1'b0;
      else if (dropped) ovf <= 1'b1;
      if (accepted) last_byte <= bus.in[7:0];
      bus.out <= status;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed bench for uart_tx_ctrl (CLKS_PER_BIT=4, depth 4).
// Written bytes go into a scoreboard; a line monitor decodes each frame on tx
// and pops the scoreboard to compare data, framing, timing and parity.
module tb_uart_tx_ctrl;

  localparam int C = 4;
  localparam int D = 4;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * C;

  typedef struct {
    logic [7:0] b;
    int         start;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  logic tx_prev = 1'b1;

  exp_t exp_q[$];
  int   starts_q[$];

  uart_tx_ctrl_if bus ();

  uart_tx_ctrl #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  // Drive one write for a single clock; k is the cycle count of the sampling edge.
  task automatic wr(input logic [15:0] d, output int k);
    bus.load = 1'b1;
    bus.in   = d;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    bus.in   = '0;
    k = cyc;
  endtask

  task automatic wait_tx_low(input int bound, output int t);
    t = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.tx === 1'b0) begin
        t = cyc;
        break;
      end
    end
    chk("tx_low_in_time", (t >= 0), 1'b1);
  endtask

  task automatic wait_idle(input int bound, output int t);
    t = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.out[14] === 1'b0) begin
        t = cyc;
        break;
      end
    end
    chk("idle_in_time", (t >= 0), 1'b1);
  endtask

  // Line monitor: every clock of every bit is sampled, so frame length and
  // bit boundaries are checked exactly, not only at mid-bit.
  int         m_start;
  logic       m_bad;
  logic       m_v;
  logic       m_stop;
  logic       m_par;
  logic [7:0] m_data;
  exp_t       m_e;

  always begin
    @(negedge clk);
    if (mon_en && tx_prev === 1'b1 && bus.tx === 1'b0) begin
      m_start = cyc;
      starts_q.push_back(m_start);
      m_bad  = 1'b0;
      m_data = '0;
      m_stop = 1'b0;
      m_par  = 1'b0;
      m_v    = 1'b0;
      for (int b = 0; b < NBITS; b++) begin
        for (int j = 0; j < C; j++) begin
          if (b != 0 || j != 0) @(negedge clk);
          if (j == 0) m_v = bus.tx;
          else if (bus.tx !== m_v) m_bad = 1'b1;
        end
        if (b >= 1 && b <= 8) m_data[b-1] = m_v;
        if (b == 9 && NBITS == 11) m_par = m_v;
        if (b == NBITS - 1) m_stop = m_v;
      end
      tx_prev = bus.tx;
      chk("frame_bits_stable", m_bad, 1'b0);
      chk("frame_stop_bit", m_stop, 1'b1);
      chk("frame_expected", (exp_q.size() != 0), 1'b1);
      if (exp_q.size() != 0) begin
        m_e = exp_q.pop_front();
        chk("frame_data", m_data, m_e.b);
        if (m_e.start >= 0) chk("frame_start_cycle", m_start, m_e.start);
`ifdef UART_PARITY_EN
        chk("frame_parity", m_par, ^m_e.b);
`endif
      end
    end else begin
      tx_prev = bus.tx;
    end
  end

  int   k;
  int   k2;
  int   t0;
  int   t1;
  logic quiet_bad;

  initial begin
    bus.load = 1'b0;
    bus.in   = '0;
    reset    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_tx", bus.tx, 1'b1);
    chk("reset_out", bus.out, 16'h0000);

    // Reset in the middle of a frame: line returns high and stays quiet.
    wr(16'h005A, k);
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midframe_reset_tx", bus.tx, 1'b1);
    chk("midframe_reset_out", bus.out, 16'h0000);
    quiet_bad = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (bus.tx !== 1'b1) quiet_bad = 1'b1;
    end
    chk("post_reset_quiet", quiet_bad, 1'b0);
    chk("post_reset_out", bus.out, 16'h0000);
    tx_prev = 1'b1;
    mon_en  = 1'b1;

    // Single byte: latency, frame length via busy, last byte.
    wr(16'h0055, k);
    exp_q.push_back('{8'h55, k + 2});
    wait_tx_low(10, t0);
    chk("single_latency", t0, k + 2);
    chk("single_busy", bus.out[14], 1'b1);
    wait_idle(100, t1);
    chk("single_busy_fall", t1 - t0, FRAME);
    chk("single_last", bus.out[7:0], 8'h55);

    // Fill the queue while idle, then overflow it mid-frame.
    for (int i = 0; i < 5; i++) begin
      wr(16'h0041 + 16'(i), k);
      exp_q.push_back('{8'h41 + 8'(i), (i == 0) ? k + 2 : -1});
    end
    wr(16'h0046, k);
    @(posedge clk);
    #1;
    chk("ovf_full", bus.out[15], 1'b1);
    chk("ovf_flag", bus.out[13], 1'b1);
    chk("ovf_count", bus.out[11:8], 4'd4);
    chk("ovf_last", bus.out[7:0], 8'h45);

    // Command write clears overflow and queues nothing.
    wr(16'h8000, k);
    @(posedge clk);
    #1;
    chk("clr_ovf", bus.out[13], 1'b0);
    chk("clr_count", bus.out[11:8], 4'd4);
    chk("clr_last", bus.out[7:0], 8'h45);
    wait_idle(400, t1);
    chk("queue_drained", exp_q.size(), 0);
    chk("idle_out", bus.out, {8'h00, 8'h45});

    // Back-to-back frames: one-clock gap, total span 2*FRAME+1.
    starts_q.delete();
    wr(16'h0000, k);
    exp_q.push_back('{8'h00, k + 2});
    wr(16'h00FF, k2);
    exp_q.push_back('{8'hFF, -1});
    repeat (3) @(posedge clk);
    wait_idle(300, t1);
    chk("b2b_frames", starts_q.size(), 2);
    if (starts_q.size() == 2) begin
      chk("b2b_gap", starts_q[1] - starts_q[0], FRAME + 1);
      chk("b2b_total", t1 - starts_q[0], 2 * FRAME + 1);
    end
    chk("b2b_last", bus.out[7:0], 8'hFF);

    // Three ones: parity bit is 1 in the parity build; frame length either way.
    wr(16'h0007, k);
    exp_q.push_back('{8'h07, k + 2});
    repeat (3) @(posedge clk);
    wait_idle(100, t1);
    chk("par_frame_len", t1 - (k + 2), FRAME);
    chk("par_last", bus.out[7:0], 8'h07);

    repeat (5) @(posedge clk);
    chk("final_sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
